lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store controller sitting in the MEM stage directly upstream of the word-wide data memory. It turns RISC-V byte, halfword and word loads and stores into word accesses on the 8-bit word-addressed memory port. Sub-word stores are done as a 2-cycle read-modify-write, and loads are sign- or zero-extended. Misaligned and illegal accesses are flagged and never reach memory.

Parameters:
ADDR_W, 8, word-address width driven to memory (byte address bits [ADDR_W+1:2]); higher address bits ignored, so addresses wrap.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  MEM-stage request present; held stable by the pipeline while stall=1
req_we  in  1  1=store, 0=load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only)
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2), low bits used for B/H
stall  out  1  hold pipeline (combinational)
ld_data  out  32  extended load result (registered)
ld_valid  out  1  one-cycle pulse, ld_data valid
lsu_err  out  1  one-cycle registered pulse: misaligned or illegal funct3
mem_addr  out  ADDR_W  word address to data memory
mem_wd  out  32  write data to data memory
dm_we  out  1  memory write enable (write occurs at posedge)
mem_rd  in  32  memory read data (combinational read)

Behaviour:
- States: IDLE, RMW_WR.
- Reset (rst_n=0 at posedge): state=IDLE, ld_data=0, ld_valid=0, lsu_err=0, internal merge buffer=0.
- While rst_n=0, dm_we=0 and stall=0 combinationally.
- Reset during RMW_WR abandons the write: no dm_we, return to IDLE.
- Error check in IDLE with req_valid=1:
  - H misaligned: addr[0]!=0.
  - W misaligned: addr[1:0]!=0.
  - Illegal: funct3 in {011,110,111}, or store with BU/HU.
  - On error: no memory write, no ld_valid, lsu_err=1 for the next cycle only, stall=0.
- mem_addr:
  - IDLE: req_addr[ADDR_W+1:2].
  - RMW_WR: the latched word address.
- Load, legal, in IDLE:
  - No stall.
  - At posedge, extract the lane from mem_rd: byte lane = addr[1:0]; halfword lane = addr[1].
  - Sign-extend for B/H, zero-extend for BU/HU, pass through for W.
  - Register the result into ld_data with ld_valid=1. Latency 1 cycle.
  - ld_data holds its value until the next load completes.
- SW, legal, in IDLE: dm_we=1, mem_wd=req_wdata in the same cycle, no stall, stay IDLE.
- SB/SH, legal, in IDLE:
  - stall=1 combinationally in the request cycle.
  - At posedge, latch word address and merged word (mem_rd with the addressed lane replaced by req_wdata[7:0] or [15:0]); go to RMW_WR.
- RMW_WR:
  - dm_we=1, mem_wd=merged word, stall=0.
  - Request inputs are ignored (they still show the same store).
  - Next state is IDLE; the pipeline advances at the end of this cycle.
- req_valid=0 in IDLE: dm_we=0, stall=0, no pulses.
- Back-to-back: a request presented in the cycle after RMW_WR returns to IDLE is accepted normally. A load immediately after an SB to the same word sees the merged value.
- Default mem_wd when dm_we=0: req_wdata (don't-care to memory).

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with req_valid=1, SW -> dm_we=0, stall=0, ld_valid=0, ld_data=0, lsu_err=0.
- SW addr=0x10 data=0xDEADBEEF, then LW addr=0x10 -> mem word 4 written; next cycle ld_valid=1, ld_data=0xDEADBEEF.
- Word 4=0xDEADBEEF:
  - LB addr=0x13 -> 0xFFFFFFDE.
  - LBU addr=0x13 -> 0x000000DE.
  - LH addr=0x10 -> 0xFFFFBEEF.
  - LHU addr=0x12 -> 0x0000DEAD.
- SB addr=0x11 wdata=0x12345677 on 0xDEADBEEF:
  - stall=1 for 1 cycle, then dm_we=1 with mem_wd=0xDEAD77EF.
  - A following LW returns 0xDEAD77EF.
- Misaligned LW addr=0x12, SH addr=0x13, and SB with funct3=100 -> lsu_err pulse each, dm_we never 1, ld_valid=0, memory unchanged.
- SH addr=0x22 with rst_n dropped in RMW_WR cycle -> dm_we=0 that cycle, state IDLE, word 8 unchanged.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for the MEM stage. Converts RISC-V byte, halfword and
// word accesses into word accesses on a word-addressed data memory. Sub-word
// stores use a two-cycle read-modify-write. Loads are extended as their funct3
// requires. Misaligned and illegal requests are reported and never touch memory.
module lsu_mem_ctrl #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       ld_data,
   output logic              ld_valid,
   output logic              lsu_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   output logic              dm_we,
   input  logic [31:0]       mem_rd
);

   typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   rmw_addr_q;
   logic [31:0]         merge_q;
   logic [31:0]         ld_data_q;
   logic                ld_valid_q;
   logic                lsu_err_q;

   logic                is_b, is_h, is_w, is_bu, is_hu;
   logic                illegal, misaligned;
   logic                req_err, ld_go, sw_go, rmw_go;
   logic [7:0]          rd_byte;
   logic [15:0]         rd_half;
   logic [31:0]         ld_ext;
   logic [31:0]         merge_d;
   logic                unused_addr;

   // Address bits above the word address are ignored, so accesses wrap.
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   // Decode the request and classify it as error, load, word store or RMW store.
   always_comb begin
      is_b       = (req_funct3 == 3'b000);
      is_h       = (req_funct3 == 3'b001);
      is_w       = (req_funct3 == 3'b010);
      is_bu      = (req_funct3 == 3'b100);
      is_hu      = (req_funct3 == 3'b101);
      illegal    = !(is_b || is_h || is_w || is_bu || is_hu) || (req_we && (is_bu || is_hu));
      misaligned = ((is_h || is_hu) && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
      req_err    = req_valid && (state_q == StIdle) && (illegal || misaligned);
      ld_go      = req_valid && (state_q == StIdle) && !req_err && !req_we;
      sw_go      = req_valid && (state_q == StIdle) && !req_err && req_we && is_w;
      rmw_go     = req_valid && (state_q == StIdle) && !req_err && req_we && (is_b || is_h);
   end

   // Lane extraction, load extension and store merge from the current memory word.
   always_comb begin
      rd_byte = mem_rd[7:0];
      unique case (req_addr[1:0])
         2'd0: rd_byte = mem_rd[7:0];
         2'd1: rd_byte = mem_rd[15:8];
         2'd2: rd_byte = mem_rd[23:16];
         2'd3: rd_byte = mem_rd[31:24];
      endcase
      rd_half = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

      ld_ext = mem_rd;
      case (req_funct3)
         3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  ld_ext = {24'h0, rd_byte};
         3'b101:  ld_ext = {16'h0, rd_half};
         default: ld_ext = mem_rd;
      endcase

      merge_d = mem_rd;
      if (is_b) begin
         unique case (req_addr[1:0])
            2'd0: merge_d[7:0]   = req_wdata[7:0];
            2'd1: merge_d[15:8]  = req_wdata[7:0];
            2'd2: merge_d[23:16] = req_wdata[7:0];
            2'd3: merge_d[31:24] = req_wdata[7:0];
         endcase
      end else if (is_h) begin
         if (req_addr[1]) begin
            merge_d[31:16] = req_wdata[15:0];
         end else begin
            merge_d[15:0] = req_wdata[15:0];
         end
      end
   end

   // Memory port and stall; reset forces the write enable and stall low.
   always_comb begin
      stall    = rst_n && rmw_go;
      dm_we    = rst_n && (sw_go || (state_q == StRmwWr));
      mem_addr = (state_q == StRmwWr) ? rmw_addr_q : req_addr[ADDR_W+1:2];
      mem_wd   = (state_q == StRmwWr) ? merge_q : req_wdata;
   end

   // FSM with registered load result and status pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rmw_addr_q <= '0;
         merge_q    <= '0;
         ld_data_q  <= '0;
         ld_valid_q <= 1'b0;
         lsu_err_q  <= 1'b0;
      end else begin
         ld_valid_q <= ld_go;
         lsu_err_q  <= req_err;
         if (ld_go) begin
            ld_data_q <= ld_ext;
         end
         unique case (state_q)
            StIdle: begin
               if (rmw_go) begin
                  rmw_addr_q <= req_addr[ADDR_W+1:2];
                  merge_q    <= merge_d;
                  state_q    <= StRmwWr;
               end
            end
            StRmwWr: state_q <= StIdle;
         endcase
      end
   end

   assign ld_data  = ld_data_q;
   assign ld_valid = ld_valid_q;
   assign lsu_err  = lsu_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed steps followed by random requests, checked
// against a byte-lane reference memory kept alongside the bench's data memory.
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] ld_data;
   logic        ld_valid;
   logic        lsu_err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wd;
   logic        dm_we;
   logic [31:0] mem_rd;

   logic [31:0] mem     [256] = '{default: 32'h0};
   logic [31:0] ref_mem [256] = '{default: 32'h0};
   logic [31:0] exp_ld;
   int          checks;
   int          failures;

   lsu_mem_ctrl #(.ADDR_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .ld_data    (ld_data),
      .ld_valid   (ld_valid),
      .lsu_err    (lsu_err),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .dm_we      (dm_we),
      .mem_rd     (mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write at posedge.
   assign mem_rd = mem[mem_addr];
   always @(posedge clk) begin
      if (dm_we) mem[mem_addr] <= mem_wd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [31:0] a);
      logic [31:0] v;
      case (f3)
         3'd0, 3'd4: begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
         end
         3'd1, 3'd5: begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] store_val(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] d);
      logic [31:0] mask;
      int          sh;
      if (f3 == 3'd0) begin
         sh   = 8 * a[1:0];
         mask = 32'hFF << sh;
      end else if (f3 == 3'd1) begin
         sh   = 16 * a[1];
         mask = 32'hFFFF << sh;
      end else begin
         sh   = 0;
         mask = 32'hFFFFFFFF;
      end
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   // One request from an IDLE cycle through to its result pulses.
   task automatic issue(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      logic        legal_f3, err, is_ld, is_sw, is_rmw, mis;
      logic [7:0]  idx;
      logic [31:0] merged;
      legal_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      mis      = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
      err      = v && (!legal_f3 || (we && f3[2]) || mis);
      is_ld    = v && !err && !we;
      is_sw    = v && !err && we && (f3 == 3'd2);
      is_rmw   = v && !err && we && (f3 != 3'd2);
      idx      = a[9:2];
      merged   = store_val(ref_mem[idx], f3, a, wd);

      req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #1;
      chk("req_stall", {31'b0, stall}, {31'b0, is_rmw});
      chk("req_dm_we", {31'b0, dm_we}, {31'b0, is_sw});
      chk("req_mem_addr", {24'b0, mem_addr}, {24'b0, idx});
      if (is_sw) chk("sw_mem_wd", mem_wd, wd);
      @(posedge clk);
      if (is_ld) exp_ld = load_val(ref_mem[idx], f3, a);
      if (is_sw) ref_mem[idx] = wd;
      #1;
      if (is_rmw) begin
         chk("rmw_dm_we", {31'b0, dm_we}, 32'd1);
         chk("rmw_stall", {31'b0, stall}, 32'd0);
         chk("rmw_mem_wd", mem_wd, merged);
         chk("rmw_mem_addr", {24'b0, mem_addr}, {24'b0, idx});
         @(posedge clk);
         ref_mem[idx] = merged;
         #1;
      end
      chk("ld_valid", {31'b0, ld_valid}, {31'b0, is_ld});
      chk("lsu_err", {31'b0, lsu_err}, {31'b0, err});
      chk("ld_data", ld_data, exp_ld);
      if (v && we) chk("mem_word", mem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [31:0] a;
      int          bad;
      checks = 0; failures = 0; exp_ld = 32'h0;

      // Reset with a word store presented: nothing may reach memory.
      rst_n = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
      #1;
      chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_ld_valid", {31'b0, ld_valid}, 32'd0);
      chk("rst_ld_data", ld_data, 32'h0);
      chk("rst_lsu_err", {31'b0, lsu_err}, 32'd0);
      chk("rst_mem4", mem[4], 32'h0);
      rst_n = 1'b1;

      // SW then LW, then every load flavour on word 4.
      issue(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw_const", ld_data, 32'hDEADBEEF);
      issue(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
      chk("lb_const", ld_data, 32'hFFFFFFDE);
      issue(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
      chk("lbu_const", ld_data, 32'h000000DE);
      issue(1'b1, 1'b0, 3'b001, 32'h10, 32'h0);
      chk("lh_const", ld_data, 32'hFFFFBEEF);
      issue(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
      chk("lhu_const", ld_data, 32'h0000DEAD);

      // SB into byte 1 followed directly by a load of the same word.
      issue(1'b1, 1'b1, 3'b000, 32'h11, 32'h12345677);
      issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      chk("sb_lw_const", ld_data, 32'hDEAD77EF);

      // Error cases leave memory and ld_data alone.
      issue(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
      issue(1'b1, 1'b1, 3'b001, 32'h13, 32'hFFFFFFFF);
      issue(1'b1, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
      issue(1'b1, 1'b0, 3'b111, 32'h10, 32'h0);
      chk("err_mem4", mem[4], 32'hDEAD77EF);

      // Reset during the RMW write cycle abandons the write.
      issue(1'b1, 1'b1, 3'b010, 32'h20, 32'h11223344);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
      req_addr = 32'h22; req_wdata = 32'h0000ABCD;
      #1;
      chk("rstrmw_stall", {31'b0, stall}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstrmw_dm_we", {31'b0, dm_we}, 32'd0);
      chk("rstrmw_stall0", {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_ld = 32'h0;
      chk("rstrmw_mem8", mem[8], 32'h11223344);
      chk("rstrmw_ld_data", ld_data, 32'h0);
      // Back in IDLE: an SW is accepted immediately with no stall.
      issue(1'b1, 1'b1, 3'b010, 32'h24, 32'h55AA55AA);

      // Random traffic over a small window with random wrapping high bits.
      for (int i = 0; i < 400; i++) begin
         a = ($urandom & 32'hFFFFFC00) | $urandom_range(0, 63);
         issue(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
               3'($urandom_range(0, 7)), a, $urandom);
      end

      req_valid = 1'b0;
      #1;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (mem[i] !== ref_mem[i]) bad++;
      end
      chk("final_mem_diffs", bad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
